// File: rtl/reduce_pkg.sv
// Shared op codes, FSM state encoding and helpers for the sequential reduction block.
package reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_NOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Accumulator start value: AND starts at 1, the others at 0.
    function automatic logic op_identity(input op_e op);
        return (op == OP_AND);
    endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Combinational fold of one CHUNK-bit slice with the base operator of the op
// (NOR folds as OR; the final inversion happens at the result register).
module reduce_chunk
    import reduce_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic [1:0]       op,
    output logic             partial
);

    always_comb begin
        partial = |chunk;
        case (op_e'(op))
            OP_AND:  partial = &chunk;
            OP_XOR:  partial = ^chunk;
            default: partial = |chunk;
        endcase
    end

endmodule

// File: rtl/reduce_seq.sv
// Sequential OR/AND/XOR/NOR reduction, one CHUNK-bit slice per clock, LSB slice first,
// with optional early exit once the result can no longer change.
module reduce_seq
    import reduce_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1,
    localparam int CW        = $clog2(WIDTH / CHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic [CW-1:0]    cycles,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int LW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_operand;
    op_e              r_op;
    logic             r_acc;
    logic [CW-1:0]    r_k;
    logic [CW-1:0]    r_cycles;
    logic             r_result;

    logic [LW-1:0]    w_lsb;
    logic [CHUNK-1:0] w_chunk;
    logic             w_partial;
    logic             w_acc_fold;
    logic             w_last;
    logic             w_decided;
    logic             w_finish;

    assign w_lsb   = LW'(r_k * CHUNK);
    assign w_chunk = r_operand[w_lsb +: CHUNK];

    reduce_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .chunk   (w_chunk),
        .op      (r_op),
        .partial (w_partial)
    );

    always_comb begin
        w_acc_fold = r_acc | w_partial;
        case (r_op)
            OP_AND:  w_acc_fold = r_acc & w_partial;
            OP_XOR:  w_acc_fold = r_acc ^ w_partial;
            default: w_acc_fold = r_acc | w_partial;
        endcase
    end

    // A 1 decides OR/NOR and a 0 decides AND; XOR is never decided early.
    assign w_last    = (r_k == CW'(N - 1));
    assign w_decided = (EARLY_EXIT != 0) &&
                       ((r_op == OP_AND) ? !w_acc_fold : ((r_op != OP_XOR) && w_acc_fold));
    assign w_finish  = w_last || w_decided;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid)  w_state_next = ST_BUSY;
                ST_BUSY: if (w_finish)  w_state_next = ST_DONE;
                ST_DONE: if (out_ready) w_state_next = ST_IDLE;
                default:                w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath registers; flush leaves result and cycles as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_operand <= '0;
            r_op      <= OP_OR;
            r_acc     <= 1'b0;
            r_k       <= '0;
            r_cycles  <= '0;
            r_result  <= 1'b0;
        end else if (!flush) begin
            if (r_state == ST_IDLE && in_valid) begin
                r_operand <= operand;
                r_op      <= op_e'(op);
                r_acc     <= op_identity(op_e'(op));
                r_k       <= '0;
                r_cycles  <= '0;
            end else if (r_state == ST_BUSY) begin
                r_acc    <= w_acc_fold;
                r_k      <= r_k + CW'(1);
                r_cycles <= r_cycles + CW'(1);
                if (w_finish) begin
                    r_result <= (r_op == OP_NOR) ? ~w_acc_fold : w_acc_fold;
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_BUSY);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_reduce_seq.sv
// Bench for reduce_seq: two instances (early exit on/off) share stimulus; a reference
// model predicts handshake and result each cycle, directed vectors pin literal values.
module tb_reduce_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] operand;
    logic        out_ready;
    logic [1:0]  ir, ov, rs, bz;
    logic [3:0]  cy_e, cy_n;
    logic [3:0]  cyv [2];

    int total = 0;
    int bad   = 0;

    assign cyv[0] = cy_e;
    assign cyv[1] = cy_n;

    reduce_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .op(op), .operand(operand), .out_valid(ov[0]), .out_ready(out_ready),
        .result(rs[0]), .cycles(cy_e), .busy(bz[0])
    );

    reduce_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .op(op), .operand(operand), .out_valid(ov[1]), .out_ready(out_ready),
        .result(rs[1]), .cycles(cy_n), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result is the plain reduction; the fold count is set by the chunk holding the
    // first deciding bit (a 1 for OR/NOR, a 0 for AND) when early exit is enabled.
    function automatic void model_calc(input logic [1:0] mop, input logic [31:0] v,
                                       input bit early, output logic res, output int cyc);
        logic want;
        case (mop)
            2'd0:    res = |v;
            2'd1:    res = &v;
            2'd2:    res = ^v;
            default: res = ~|v;
        endcase
        cyc  = 8;
        want = (mop != 2'd1);
        if (early && mop != 2'd2) begin
            for (int i = 0; i < 32; i++) begin
                if (v[i] == want) begin
                    cyc = i / 4 + 1;
                    break;
                end
            end
        end
    endfunction

    // Model phases: 0 idle, 1 folding, 2 result offered.
    int   m_phase [2];
    int   m_left  [2];
    logic m_res   [2];
    int   m_cyc   [2];
    logic m_pres  [2];
    int   m_pcyc  [2];

    always @(posedge clk or negedge rst_n) begin : model
        logic mr;
        int   mc;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] <= 0;
                m_left[d]  <= 0;
                m_res[d]   <= 1'b0;
                m_cyc[d]   <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (flush) begin
                    m_phase[d] <= 0;
                end else begin
                    case (m_phase[d])
                        0: if (in_valid) begin
                            model_calc(op, operand, d == 0, mr, mc);
                            m_phase[d] <= 1;
                            m_left[d]  <= mc;
                            m_pres[d]  <= mr;
                            m_pcyc[d]  <= mc;
                        end
                        1: begin
                            if (m_left[d] == 1) begin
                                m_phase[d] <= 2;
                                m_res[d]   <= m_pres[d];
                                m_cyc[d]   <= m_pcyc[d];
                            end
                            m_left[d] <= m_left[d] - 1;
                        end
                        default: if (out_ready) m_phase[d] <= 0;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                bit ok;
                ok = (ir[d] == (m_phase[d] == 0)) && (bz[d] == (m_phase[d] == 1)) &&
                     (ov[d] == (m_phase[d] == 2));
                if (m_phase[d] == 2)
                    ok = ok && (rs[d] == m_res[d]) && (int'(cyv[d]) == m_cyc[d]);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL model_cycle dut%0d t=%0t: got rdy=%b busy=%b vld=%b res=%b cyc=%0d, want phase=%0d res=%b cyc=%0d",
                             d, $time, ir[d], bz[d], ov[d], rs[d], cyv[d], m_phase[d], m_res[d], m_cyc[d]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic [1:0] t_op, input logic [31:0] t_v, input logic t_res,
                           input int t_ce, input int t_cn, input int hold);
        int lat_e, lat_n;
        chk("in_ready_before_accept", int'(ir), 3);
        op       = t_op;
        operand  = t_v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        operand = $urandom;
        op      = 2'($urandom_range(0, 3));
        lat_e = 0;
        lat_n = 0;
        for (int n = 0; n <= 40; n++) begin
            if (ov[0] && lat_e == 0) lat_e = n;
            if (ov[1] && lat_n == 0) lat_n = n;
            if (lat_e != 0 && lat_n != 0) break;
            @(negedge clk);
        end
        chk("latency_early", lat_e, t_ce);
        chk("latency_full", lat_n, t_cn);
        repeat (hold) @(negedge clk);
        chk("out_valid_held", int'(ov), 3);
        chk("in_ready_while_done", int'(ir), 0);
        chk("result_early", int'(rs[0]), int'(t_res));
        chk("result_full", int'(rs[1]), int'(t_res));
        chk("cycles_early", int'(cy_e), t_ce);
        chk("cycles_full", int'(cy_n), t_cn);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_take_rdy", int'(ir), 3);
        chk("idle_after_take_vld", int'(ov), 0);
        $display("txn op=%0d operand=%08h result=%b/%b cycles=%0d/%0d", t_op, t_v, rs[0], rs[1], cy_e, cy_n);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] v;
        logic        res;
        int          ce;
        int          cn;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{2'd0, 32'h0000_0000, 1'b0, 8, 8};
        vecs[1] = '{2'd0, 32'h0000_0010, 1'b1, 2, 8};
        vecs[2] = '{2'd3, 32'h0000_0000, 1'b1, 8, 8};
        vecs[3] = '{2'd1, 32'hFFFF_FFFF, 1'b1, 8, 8};
        vecs[4] = '{2'd1, 32'hFFFF_FFF0, 1'b0, 1, 8};
        vecs[5] = '{2'd2, 32'h8000_0001, 1'b0, 8, 8};
        vecs[6] = '{2'd2, 32'h8000_0000, 1'b1, 8, 8};
        vecs[7] = '{2'd3, 32'h00F0_0000, 1'b0, 6, 8};
        vecs[8] = '{2'd0, 32'h8000_0000, 1'b1, 8, 8};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 2'd0; operand = '0; out_ready = 1'b0;
        #1;
        chk("reset_in_ready", int'(ir), 3);
        chk("reset_out_valid", int'(ov), 0);
        chk("reset_busy", int'(bz), 0);
        chk("reset_cycles", int'(cy_e) + int'(cy_n), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].op, vecs[i].v, vecs[i].res, vecs[i].ce, vecs[i].cn, (i == 3) ? 5 : 1);

        // Asynchronous reset while the third XOR fold is pending.
        op = 2'd2; operand = 32'h8000_0000; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", int'(ir), 3);
        chk("async_rst_out_valid", int'(ov), 0);
        chk("async_rst_busy", int'(bz), 0);
        chk("async_rst_result", int'(rs), 0);
        chk("async_rst_cycles_e", int'(cy_e), 0);
        chk("async_rst_cycles_n", int'(cy_n), 0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_txn(2'd0, 32'h0000_0010, 1'b1, 2, 8, 1);

        // Flush after two folds of a full-length AND.
        op = 2'd1; operand = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_before_flush", int'(bz), 3);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", int'(bz), 0);
        chk("flush_in_ready", int'(ir), 3);
        chk("flush_out_valid", int'(ov), 0);
        chk("flush_result_kept", int'(rs), 3);
        chk("flush_cycles_e", int'(cy_e), 2);
        chk("flush_cycles_n", int'(cy_n), 2);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("no_valid_after_flush", int'(ov), 0);
        end
        $display("txn flush done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
